// File: rtl/clock_set_ctrl_12hr.sv
// Time-setting controller for a 12-hour BCD clock core: walks hour, minute and
// AM/PM fields on button pulses and loads the edited time back into the core.
module clock_set_ctrl_12hr #(
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic       cur_pm,
  output logic       ena,
  output logic       load,
  output logic [7:0] ld_hh,
  output logic [7:0] ld_mm,
  output logic [7:0] ld_ss,
  output logic       ld_pm,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_PM = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);

  state_t          state, state_nx;
  logic [7:0]      hh, hh_nx;
  logic [7:0]      mm, mm_nx;
  logic            pm, pm_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            blink_r, blink_nx;
  logic            load_r, load_nx;

  // Hours outside the legal 01..12 BCD range recover to 01.
  function automatic logic [7:0] hour_step(input logic [7:0] h);
    logic valid;
    valid = (h == 8'h10) || (h == 8'h11) || (h == 8'h12) ||
            ((h[7:4] == 4'd0) && (h[3:0] != 4'd0) && (h[3:0] <= 4'd9));
    if (!valid || h == 8'h12) return 8'h01;
    if (h == 8'h09)           return 8'h10;
    return h + 8'h01;
  endfunction

  function automatic logic [7:0] min_step(input logic [7:0] m);
    if (m[3:0] >= 4'd9) begin
      if (m[7:4] >= 4'd5) return 8'h00;
      return {m[7:4] + 4'd1, 4'd0};
    end
    return m + 8'h01;
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nx = state;
    hh_nx    = hh;
    mm_nx    = mm;
    pm_nx    = pm;
    cnt_nx   = cnt;
    blink_nx = blink_r;
    load_nx  = 1'b0;

    if (state == RUN) begin
      cnt_nx   = '0;
      blink_nx = 1'b0;
      if (btn_mode) begin
        state_nx = SET_HH;
        hh_nx    = cur_hh;
        mm_nx    = cur_mm;
        pm_nx    = cur_pm;
        blink_nx = 1'b1;
      end
    end else if (btn_mode) begin
      cnt_nx = '0;
      if (state == SET_PM) begin
        state_nx = RUN;
        load_nx  = 1'b1;
        blink_nx = 1'b0;
      end else begin
        state_nx = state_t'(state + 2'd1);
        blink_nx = 1'b1;
      end
    end else begin
      if (btn_inc) begin
        cnt_nx = '0;
        unique case (state)
          SET_HH:  hh_nx = hour_step(hh);
          SET_MM:  mm_nx = min_step(mm);
          default: pm_nx = ~pm;
        endcase
      end else if (tick) begin
        cnt_nx = cnt + CW'(1);
      end
      // Abandon set mode without loading once the idle count is exhausted.
      if (tick) begin
        if (!btn_inc && cnt == CW'(TIMEOUT_TICKS - 1)) begin
          state_nx = RUN;
          blink_nx = 1'b0;
        end else begin
          blink_nx = ~blink_r;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      hh      <= 8'h12;
      mm      <= 8'h00;
      pm      <= 1'b0;
      cnt     <= '0;
      blink_r <= 1'b0;
      load_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      hh      <= hh_nx;
      mm      <= mm_nx;
      pm      <= pm_nx;
      cnt     <= cnt_nx;
      blink_r <= blink_nx;
      load_r  <= load_nx;
    end
  end

  assign ena   = (state == RUN) && !load_r && tick && !reset;
  assign load  = load_r;
  assign ld_hh = hh;
  assign ld_mm = mm;
  assign ld_ss = 8'h00;
  assign ld_pm = pm;
  assign mode  = state;
  assign blink = blink_r;

endmodule

// File: tb/tb_clock_set_ctrl_12hr.sv
// Bench for clock_set_ctrl_12hr: directed scenarios plus random stimulus, all
// compared every cycle against a field-level model of the set procedure.
module tb_clock_set_ctrl_12hr;

  localparam int TO = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0, tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [7:0] cur_hh = 8'h12, cur_mm = 8'h00;
  logic       cur_pm = 1'b0;
  logic       ena, load, ld_pm, blink;
  logic [7:0] ld_hh, ld_mm, ld_ss;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0..3, shadow time as BCD bytes, idle tick count.
  int         m_mode = 0;
  int         m_cnt  = 0;
  bit         m_load = 0, m_blink = 0, m_pm = 0;
  logic [7:0] m_hh = 8'h12, m_mm = 8'h00;

  clock_set_ctrl_12hr #(.TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_pm(cur_pm),
    .ena(ena), .load(load), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
    .ld_pm(ld_pm), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [7:0] next_hour(input logic [7:0] h);
    int v;
    v = bcd2int(h);
    if (v < 1 || v >= 12) return int2bcd(1);
    return int2bcd(v + 1);
  endfunction

  function automatic logic [7:0] next_min(input logic [7:0] m);
    return int2bcd((bcd2int(m) + 1) % 60);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit t, input bit bm, input bit bi, input bit r);
    bit ld;
    ld = 0;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_blink = 0; m_hh = 8'h12; m_mm = 8'h00; m_pm = 0;
    end else if (m_mode == 0) begin
      if (bm) begin
        m_mode = 1; m_cnt = 0; m_blink = 1;
        m_hh = cur_hh; m_mm = cur_mm; m_pm = cur_pm;
      end
    end else if (bm) begin
      m_mode = (m_mode + 1) % 4;
      m_cnt = 0;
      if (m_mode == 0) begin ld = 1; m_blink = 0; end
      else m_blink = 1;
    end else begin
      if (bi) begin
        m_cnt = 0;
        case (m_mode)
          1: m_hh = next_hour(m_hh);
          2: m_mm = next_min(m_mm);
          default: m_pm = !m_pm;
        endcase
      end else if (t) m_cnt++;
      if (t) begin
        if (m_cnt == TO) begin m_mode = 0; m_blink = 0; end
        else m_blink = !m_blink;
      end
    end
    m_load = ld;
  endtask

  // One clock: drive at negedge, check ena before the edge, outputs after it.
  task automatic cycle(input bit t, input bit bm, input bit bi, input bit r);
    tick = t; btn_mode = bm; btn_inc = bi; reset = r;
    #1;
    check("ena", {7'd0, ena}, {7'd0, (m_mode == 0) && !m_load && t && !r});
    @(posedge clk);
    model_step(t, bm, bi, r);
    #1;
    check("mode",  {6'd0, mode},  m_mode[7:0]);
    check("load",  {7'd0, load},  {7'd0, m_load});
    check("blink", {7'd0, blink}, {7'd0, m_blink});
    check("ld_hh", ld_hh, m_hh);
    check("ld_mm", ld_mm, m_mm);
    check("ld_pm", {7'd0, ld_pm}, {7'd0, m_pm});
    check("ld_ss", ld_ss, 8'h00);
    @(negedge clk);
    tick = 0; btn_mode = 0; btn_inc = 0; reset = 0;
  endtask

  initial begin
    logic [7:0] wrap_exp [4];
    wrap_exp[0] = 8'h10; wrap_exp[1] = 8'h11; wrap_exp[2] = 8'h12; wrap_exp[3] = 8'h01;

    @(negedge clk);
    cycle(0, 0, 0, 1);
    cycle(1, 1, 1, 1);
    check("reset_mode", {6'd0, mode}, 8'd0);
    check("reset_hh", ld_hh, 8'h12);

    // RUN: ena follows tick, btn_inc ignored.
    for (int i = 0; i < 20; i++) cycle(i % 5 == 0, 0, i % 3 == 0, 0);

    // Full set sequence from 11:58 PM.
    cur_hh = 8'h11; cur_mm = 8'h58; cur_pm = 1'b1;
    cycle(0, 1, 0, 0); cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0); cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0); cycle(0, 0, 1, 0);
    cycle(1, 1, 0, 0);
    check("seq_load", {7'd0, load}, 8'd1);
    check("seq_hh", ld_hh, 8'h12);
    check("seq_mm", ld_mm, 8'h00);
    check("seq_pm", {7'd0, ld_pm}, 8'd0);
    cycle(1, 0, 0, 0);
    check("seq_load_done", {7'd0, load}, 8'd0);
    check("seq_mode_run", {6'd0, mode}, 8'd0);

    // Hour wrap from 09.
    cur_hh = 8'h09; cur_mm = 8'h30; cur_pm = 1'b0;
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0);
      check("hour_wrap", ld_hh, wrap_exp[i]);
    end
    cycle(0, 1, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);

    // Timeout from SET_MM after 30 idle ticks.
    cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
    for (int i = 0; i < TO; i++) begin
      cycle(1, 0, 0, 0);
      check("timeout_mode", {6'd0, mode}, (i == TO - 1) ? 8'd0 : 8'd2);
      check("timeout_noload", {7'd0, load}, 8'd0);
      cycle(0, 0, 0, 0);
    end

    // btn_mode wins over btn_inc in SET_HH.
    cur_hh = 8'h05;
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    check("prio_mode", {6'd0, mode}, 8'd2);
    check("prio_hh", ld_hh, 8'h05);

    // Reset in SET_PM.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 1);
    check("rst_pm_mode", {6'd0, mode}, 8'd0);
    check("rst_pm_load", {7'd0, load}, 8'd0);
    check("rst_pm_hh", ld_hh, 8'h12);
    cycle(0, 0, 0, 0);

    // Random traffic: busy buttons first, then sparse buttons so timeouts occur.
    for (int i = 0; i < 4000; i++) begin
      bit t, bm, bi, r;
      if ($urandom_range(0, 9) == 0) cur_hh = 8'($urandom);
      else cur_hh = int2bcd(int'($urandom_range(1, 12)));
      cur_mm = int2bcd(int'($urandom_range(0, 59)));
      cur_pm = 1'($urandom);
      if (i < 2000) begin
        t  = ($urandom_range(0, 5) == 0);
        bm = ($urandom_range(0, 11) == 0);
        bi = ($urandom_range(0, 3) == 0);
      end else begin
        t  = ($urandom_range(0, 1) == 0);
        bm = ($urandom_range(0, 59) == 0);
        bi = ($urandom_range(0, 39) == 0);
      end
      r = ($urandom_range(0, 299) == 0);
      cycle(t, bm, bi, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl_12hr.md
CLOCK_SET_CTRL_12HR -- requirements
Module: clock_set_ctrl_12hr

Interface
REQ-001 Parameter: TIMEOUT_TICKS, default 30, number of 1 Hz ticks without a button pulse before set mode is abandoned.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick  input  1  single-cycle 1 Hz strobe.
REQ-005 btn_mode  input  1  debounced single-cycle pulse; advances the set field.
REQ-006 btn_inc  input  1  debounced single-cycle pulse; increments the selected field.
REQ-007 cur_hh  input  8  live hours from the clock core, BCD 01..12.
REQ-008 cur_mm  input  8  live minutes from the clock core, BCD 00..59.
REQ-009 cur_pm  input  1  live PM flag from the clock core.
REQ-010 ena  output  1  count enable to the clock core.
REQ-011 load  output  1  single-cycle strobe; the clock core shall adopt ld_* values on this strobe.
REQ-012 ld_hh, ld_mm, ld_ss  output  8 each  shadow time in BCD; ld_ss is constant 8'h00.
REQ-013 ld_pm  output  1  shadow PM flag.
REQ-014 mode  output  2  state encoding: 0 RUN, 1 SET_HH, 2 SET_MM, 3 SET_PM.
REQ-015 blink  output  1  display blink phase for the selected field.

Function
REQ-016 The FSM shall have four states, RUN -> SET_HH -> SET_MM -> SET_PM -> RUN, and shall advance one state per btn_mode pulse.
REQ-017 ena shall equal tick only in RUN with load=0; ena shall be 0 in all other cases.
REQ-018 The RUN->SET_HH transition shall copy cur_hh, cur_mm and cur_pm into the shadow registers in the same edge; ticks during set mode are dropped (time frozen).
REQ-019 In SET_HH, btn_inc shall step the hour: 12->01, 09->10, any value outside 01..12 ->01, otherwise BCD +1; pm shall not change.
REQ-020 In SET_MM, btn_inc shall step the minute in BCD: x9->(x+1)0, 59->00; there shall be no carry into the hour.
REQ-021 In SET_PM, btn_inc shall toggle the shadow pm.
REQ-022 When btn_mode and btn_inc arrive in the same cycle, btn_mode takes priority and btn_inc is ignored.
REQ-023 btn_inc in RUN shall be ignored.
REQ-024 btn_mode in SET_PM shall return the FSM to RUN and assert load for exactly the next cycle; ena shall be 0 in that load cycle.
REQ-025 Timeout counter operation in SET_* states:
- cleared on entry to SET_HH;
- cleared on every btn_mode or btn_inc pulse;
- incremented on each tick.
REQ-026 When the timeout counter reaches TIMEOUT_TICKS, the FSM shall return to RUN with no load pulse, discarding the shadow edits.
REQ-027 blink shall be 0 in RUN, shall be set to 1 on every state entry, and shall toggle on each tick while in SET_* states.
REQ-028 The ld_* outputs shall continuously reflect the shadow registers; they are meaningful only while load=1.

Reset
REQ-029 During reset the block shall drive:
- mode=0 (RUN), ena=0, load=0, blink=0;
- ld_hh=8'h12, ld_mm=8'h00, ld_ss=8'h00, ld_pm=0;
- timeout counter cleared.
REQ-030 Reset asserted in any SET_* state shall return the FSM to RUN in the next cycle with no load pulse.

Verification
REQ-031 RUN state: drive tick every 5 cycles -> ena pulses coincide with tick; btn_inc has no effect; load stays 0.
REQ-032 Full set sequence: cur=11:58 PM. Apply btn_mode, 1x btn_inc (hh->12), btn_mode, 2x btn_inc (58->59->00), btn_mode, 1x btn_inc (pm->0), btn_mode. Required: one-cycle load with ld_hh=8'h12, ld_mm=8'h00, ld_ss=8'h00, ld_pm=0; mode=0 afterwards.
REQ-033 Hour wrap: starting from 09 in SET_HH, apply 4x btn_inc -> shadow steps 10, 11, 12, 01.
REQ-034 Timeout: enter SET_MM, then issue 30 ticks with no buttons -> mode=0 on the 30th tick, load never asserted.
REQ-035 btn_mode and btn_inc in the same cycle in SET_HH -> mode=2, hour unchanged.
REQ-036 Assert reset in SET_PM -> mode=0, load=0, ld_hh=8'h12 on the next cycle.
